n2_iq: RTL
==========

N2_IQ -- requirements
Module: N2_iq

Interface
REQ-001 SHALL have parameter DEPTH, default 4: entry count; power of two; pointers are log2(DEPTH)+1 = 3 bits.
REQ-002 clk  in  1  clock.
REQ-003 resetn  in  1  reset, asynchronous, active-low.
REQ-004 flush_i  in  1  redirect; discard all queued and in-flight instructions.
REQ-005 instr_rvalid_i  in  1  fetch response valid, one per granted request, in request order.
REQ-006 instr_rvalid_2b_i  in  2  response word valids; legal values 01 (word0 only) or 11.
REQ-007 instr_rdata_i  in  64  word0 in [31:0], word1 in [63:32].
REQ-008 btb_ctl_m0_v_i, btb_ctl_m1_v_i  in  1 each  prediction sideband valid for word0/word1.
REQ-009 btb_ctl_m0_i, btb_ctl_m1_i  in  btb_ctl_t  pc[15:0], jump, tgt[15:0] for word0/word1.
REQ-010 iq_prefetch_ptr_i  in  3  fetch-unit allocation pointer.
REQ-011 iq_rd_ptr_o  out  3  queue read pointer, returned to fetch unit for its stall calculation.
REQ-012 id_v_o  out  2  issue slot valids; only 00, 01 or 11.
REQ-013 id_entry_o  out  2 x iq_entry_t  slot0 = oldest entry.
REQ-014 id_accept_i  in  2  decode consumes; only 00, 01 or 11, and only accepts slots that are valid.

Function
REQ-015 Write pointer wr_ptr (3 bits) SHALL advance by 1 or 2 on each kept response, storing word0 then word1 at wr_ptr[1:0], wr_ptr[1:0]+1 (mod DEPTH).
REQ-016 Each stored entry SHALL hold instr, pc, jump and tgt from the matching word and btb_ctl sideband.
REQ-017 A word whose btb_ctl_mX_v_i is 0 SHALL be stored with jump=0, and pc = previous entry pc + 4.
REQ-018 Occupancy SHALL be wr_ptr - iq_rd_ptr_o (3-bit wrap arithmetic).
REQ-019 id_v_o[0] SHALL be set when occupancy >= 1; id_v_o[1] when occupancy >= 2 and slot0.jump = 0.
REQ-020 Issue outputs SHALL be combinational from registered entries; a word written at edge N is issuable in the cycle after edge N; no write-to-issue bypass.
REQ-021 iq_rd_ptr_o SHALL advance by popcount(id_accept_i) at each edge.
REQ-022 Overflow is impossible by contract: the fetch unit stalls at 4 allocated entries. The block SHALL flag an assertion if a write would exceed DEPTH.
REQ-023 FSM states:
- RUN: responses are written.
- DRAIN: responses are discarded.
REQ-024 On flush_i in any state:
- iq_rd_ptr_o <= iq_prefetch_ptr_i, wr_ptr <= iq_prefetch_ptr_i;
- drop_cnt <= iq_prefetch_ptr_i - wr_ptr - (words of any response arriving in this same cycle);
- go to DRAIN if drop_cnt != 0, else RUN.
REQ-025 In DRAIN, each response SHALL decrement drop_cnt by its word count without writing. Return to RUN when drop_cnt reaches 0.
REQ-026 During a flush cycle, id_accept_i SHALL be ignored and a response arriving in that cycle SHALL be discarded.
REQ-027 When flush_i deasserts, the first response from the redirect path SHALL be written at wr_ptr = the iq_prefetch_ptr_i value sampled at the flush.

Reset
REQ-028 On resetn low:
- iq_rd_ptr_o = 0, wr_ptr = 0, drop_cnt = 0, state = RUN;
- id_v_o = 00; entry contents are don't-care.

Structure
REQ-029 NanoCore_pkg SHALL hold:
- iq_entry_t {instr[31:0], pc[15:0], jump, tgt[15:0]};
- existing btb_ctl_t;
- localparam IQ_DEPTH = 4.
REQ-030 One sub-module, N2_iq_drain, SHALL implement the drop_cnt/FSM logic. Entry storage and pointers SHALL stay in N2_iq.

Verification
REQ-031 Reset, then a response with 2b=11, rdata=0x00000013_00100093 -> next cycle id_v_o=11, slot0.instr=0x00100093, slot1.instr=0x00000013.
REQ-032 Four single-word responses with no accepts -> occupancy 4, id_v_o=11; then accept=11 -> iq_rd_ptr_o +2.
REQ-033 Slot0 stored with jump=1, tgt=0x0040 and occupancy 2 -> id_v_o=01.
REQ-034 prefetch_ptr=5, wr_ptr=3, flush -> DRAIN with drop_cnt=2; one 2-word stale response is discarded; the next response is written at index 5 and is visible next cycle.
REQ-035 Flush coincident with a response and accept=11 -> pointers equal iq_prefetch_ptr_i, id_v_o=00, no write.
REQ-036 Pointer wrap 7 -> 0 across a 2-word write -> entries land at indices 3 and 0, issued in order.

Source files
------------

// File: rtl/nanocore_pkg.sv
// Shared NanoCore types for the instruction queue: branch-prediction sideband,
// queue entry layout and the default queue depth.
package nanocore_pkg;

  localparam int IQ_DEPTH = 4;

  typedef struct packed {
    logic [15:0] pc;
    logic        jump;
    logic [15:0] tgt;
  } btb_ctl_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [15:0] pc;
    logic        jump;
    logic [15:0] tgt;
  } iq_entry_t;

  // Number of instruction words carried by a fetch response (01 -> 1, 11 -> 2).
  function automatic logic [1:0] word_count(input logic [1:0] valid_2b);
    return {1'b0, valid_2b[0]} + {1'b0, valid_2b[1]};
  endfunction

endpackage

// File: rtl/n2_iq_drain.sv
// Redirect drain tracker: counts fetch responses still in flight from the old
// path after a flush so that they can be dropped before normal writes resume.
module n2_iq_drain #(
  parameter int PW = 3
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush_i,
  input  logic          rsp_v,
  input  logic [1:0]    rsp_words,
  input  logic [PW-1:0] prefetch_ptr,
  input  logic [PW-1:0] wr_ptr,
  output logic          draining,
  output logic [PW-1:0] drop_cnt
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [0:0]    state_reg, state_next;
  logic [PW-1:0] drop_cnt_reg, drop_cnt_next;
  logic [PW-1:0] words_ext;

  assign words_ext = rsp_v ? PW'(rsp_words) : '0;

  always_comb begin
    state_next    = state_reg;
    drop_cnt_next = drop_cnt_reg;
    if (flush_i) begin
      // A response landing in the flush cycle is already one of the stale ones.
      drop_cnt_next = prefetch_ptr - wr_ptr - words_ext;
      state_next    = (drop_cnt_next != '0) ? ST_DRAIN : ST_RUN;
    end else if (state_reg == ST_DRAIN && rsp_v) begin
      if (words_ext >= drop_cnt_reg) begin
        drop_cnt_next = '0;
        state_next    = ST_RUN;
      end else begin
        drop_cnt_next = drop_cnt_reg - words_ext;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= ST_RUN;
      drop_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  assign draining = (state_reg == ST_DRAIN);
  assign drop_cnt = drop_cnt_reg;

endmodule

// File: rtl/n2_iq.sv
// Two-wide instruction queue between fetch and decode: stores fetched words with
// their prediction sideband and presents the two oldest entries for issue.
module n2_iq
  import nanocore_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          flush_i,
  input  logic                          instr_rvalid_i,
  input  logic [1:0]                    instr_rvalid_2b_i,
  input  logic [63:0]                   instr_rdata_i,
  input  logic                          btb_ctl_m0_v_i,
  input  logic                          btb_ctl_m1_v_i,
  input  btb_ctl_t                      btb_ctl_m0_i,
  input  btb_ctl_t                      btb_ctl_m1_i,
  input  logic [$clog2(DEPTH):0]        iq_prefetch_ptr_i,
  output logic [$clog2(DEPTH):0]        iq_rd_ptr_o,
  output logic [1:0]                    id_v_o,
  output iq_entry_t [1:0]               id_entry_o,
  input  logic [1:0]                    id_accept_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  iq_entry_t     entries [DEPTH];
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [15:0]   last_pc_reg;
  logic [PW-1:0] occupancy;
  logic [1:0]    rsp_words;
  logic [1:0]    accept_cnt;
  logic          draining;
  logic [PW-1:0] drop_cnt;
  logic          keep;
  logic          two_words;
  logic [AW-1:0] wr_idx0, wr_idx1;
  logic [AW-1:0] rd_idx0, rd_idx1;
  iq_entry_t     wr_entry0, wr_entry1;

  assign rsp_words  = word_count(instr_rvalid_2b_i);
  assign accept_cnt = {1'b0, id_accept_i[0]} + {1'b0, id_accept_i[1]};
  assign keep       = instr_rvalid_i && !flush_i && !draining;
  assign two_words  = instr_rvalid_2b_i[1];

  n2_iq_drain #(
    .PW(PW)
  ) u_drain (
    .clk          (clk),
    .resetn       (resetn),
    .flush_i      (flush_i),
    .rsp_v        (instr_rvalid_i),
    .rsp_words    (rsp_words),
    .prefetch_ptr (iq_prefetch_ptr_i),
    .wr_ptr       (wr_ptr_reg),
    .draining     (draining),
    .drop_cnt     (drop_cnt)
  );

  // Words without a prediction are assumed sequential to the last stored word.
  always_comb begin
    wr_entry0.instr = instr_rdata_i[31:0];
    wr_entry0.pc    = btb_ctl_m0_v_i ? btb_ctl_m0_i.pc : last_pc_reg + 16'd4;
    wr_entry0.jump  = btb_ctl_m0_v_i & btb_ctl_m0_i.jump;
    wr_entry0.tgt   = btb_ctl_m0_v_i ? btb_ctl_m0_i.tgt : 16'h0000;
    wr_entry1.instr = instr_rdata_i[63:32];
    wr_entry1.pc    = btb_ctl_m1_v_i ? btb_ctl_m1_i.pc : wr_entry0.pc + 16'd4;
    wr_entry1.jump  = btb_ctl_m1_v_i & btb_ctl_m1_i.jump;
    wr_entry1.tgt   = btb_ctl_m1_v_i ? btb_ctl_m1_i.tgt : 16'h0000;
  end

  assign wr_idx0 = wr_ptr_reg[AW-1:0];
  assign wr_idx1 = wr_idx0 + AW'(1);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (keep && wr_idx0 == AW'(gi)) begin
          entries[gi] <= wr_entry0;
        end else if (keep && two_words && wr_idx1 == AW'(gi)) begin
          entries[gi] <= wr_entry1;
        end
      end
    end
  endgenerate

  always_comb begin
    rd_ptr_next = rd_ptr_reg + PW'(accept_cnt);
    wr_ptr_next = wr_ptr_reg;
    if (keep) begin
      wr_ptr_next = wr_ptr_reg + PW'(rsp_words);
    end
    if (flush_i) begin
      rd_ptr_next = iq_prefetch_ptr_i;
      wr_ptr_next = iq_prefetch_ptr_i;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      last_pc_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      if (keep) begin
        last_pc_reg <= two_words ? wr_entry1.pc : wr_entry0.pc;
      end
    end
  end

  assign occupancy = wr_ptr_reg - rd_ptr_reg;
  assign rd_idx0   = rd_ptr_reg[AW-1:0];
  assign rd_idx1   = rd_idx0 + AW'(1);

  // Slot1 is held back behind a predicted-taken slot0 so decode redirects first.
  assign id_v_o[0]     = (occupancy != '0);
  assign id_v_o[1]     = (occupancy > PW'(1)) && !entries[rd_idx0].jump;
  assign id_entry_o[0] = entries[rd_idx0];
  assign id_entry_o[1] = entries[rd_idx1];
  assign iq_rd_ptr_o   = rd_ptr_reg;

  logic [PW:0] occ_after_write;
  assign occ_after_write = {1'b0, occupancy} + (PW+1)'(rsp_words) - (PW+1)'(accept_cnt);

  a_no_overflow : assert property (@(posedge clk) disable iff (!resetn)
    keep |-> (occ_after_write <= (PW+1)'(DEPTH)));

  logic unused_drop_cnt;
  assign unused_drop_cnt = ^drop_cnt;

endmodule
